// File: rtl/spi_seq_arb.sv
// Round-robin arbiter and byte sequencer for a single spi register port.
// Two requesters post header bytes plus a receive length; received bytes stream out.
module spi_seq_arb #(
  parameter int         HDR_BYTES = 5,
  parameter int         LEN_W     = 8,
  parameter logic [7:0] FILL      = 8'hFF,
  parameter int         TO_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [3:0]                 req_sel,
  input  logic [2*8*HDR_BYTES-1:0]   req_hdr,
  input  logic [5:0]                 req_hdr_len,
  input  logic [2*LEN_W-1:0]         req_rx_len,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [7:0]                 rx_data,
  output logic                       rx_id,
  output logic [1:0]                 done,
  output logic                       err,
  output logic                       busy,
  output logic [2:0]                 spi_reg_addr,
  output logic [7:0]                 spi_reg_data,
  output logic [1:0]                 spi_reg_sel,
  output logic                       spi_reg_read,
  output logic                       spi_reg_write,
  input  logic [7:0]                 spi_rdata,
  input  logic                       spi_int
);

  localparam int CNT_W  = 3 + LEN_W;
  localparam int HIDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_WR, S_RD, S_HOLD, S_END, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      rx_id_q, rx_id_d;
  logic [1:0]                sel_q, sel_d;
  logic [HDR_BYTES-1:0][7:0] hdr_q, hdr_d;
  logic [2:0]                hdr_len_q, hdr_len_d;
  logic [LEN_W-1:0]          rx_len_q, rx_len_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]           wd_q, wd_d;
  logic                      err_q, err_d;
  logic                      rx_valid_q, rx_valid_d;
  logic [7:0]                rx_data_q, rx_data_d;

  logic                      gnt_port;
  logic [2:0]                gnt_hdr_len;
  logic                      gnt_bad;
  logic [CNT_W-1:0]          total;
  logic                      last_byte;
  logic                      hdr_phase;

  // With both ports pending, the one not served last time wins.
  assign gnt_port    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign gnt_hdr_len = gnt_port ? req_hdr_len[5:3] : req_hdr_len[2:0];
  assign gnt_bad     = (gnt_hdr_len == 3'd0) || (int'(gnt_hdr_len) > HDR_BYTES);
  assign total       = CNT_W'(hdr_len_q) + CNT_W'(rx_len_q);
  assign last_byte   = (byte_cnt_q == total);
  assign hdr_phase   = (byte_cnt_q <= CNT_W'(hdr_len_q));

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    rx_id_d       = rx_id_q;
    sel_d         = sel_q;
    hdr_d         = hdr_q;
    hdr_len_d     = hdr_len_q;
    rx_len_d      = rx_len_q;
    byte_cnt_d    = byte_cnt_q;
    wd_d          = wd_q;
    err_d         = err_q;
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    req_ready     = 2'b00;
    done          = 2'b00;
    err           = 1'b0;
    spi_reg_addr  = 3'd0;
    spi_reg_data  = 8'd0;
    spi_reg_read  = 1'b0;
    spi_reg_write = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((|req_valid) && !reset) begin
          req_ready[gnt_port] = 1'b1;
          last_grant_d = gnt_port;
          rx_id_d      = gnt_port;
          sel_d        = gnt_port ? req_sel[3:2] : req_sel[1:0];
          hdr_d        = gnt_port ? req_hdr[2*8*HDR_BYTES-1:8*HDR_BYTES]
                                  : req_hdr[8*HDR_BYTES-1:0];
          hdr_len_d    = gnt_hdr_len;
          rx_len_d     = gnt_port ? req_rx_len[2*LEN_W-1:LEN_W] : req_rx_len[LEN_W-1:0];
          err_d        = gnt_bad;
          state_d      = gnt_bad ? S_DONE : S_START;
        end
      end
      S_START: begin
        spi_reg_write = 1'b1;
        spi_reg_data  = hdr_q[0];
        byte_cnt_d    = CNT_W'(1);
        wd_d          = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (spi_int) begin
          if (hdr_phase) state_d = (byte_cnt_q < total) ? S_WR : S_END;
          else           state_d = S_RD;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == '1) begin
            err_d   = 1'b1;
            state_d = S_END;
          end
        end
      end
      S_WR: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        spi_reg_data  = (byte_cnt_q < CNT_W'(hdr_len_q)) ? hdr_q[byte_cnt_q[HIDX_W-1:0]] : FILL;
        byte_cnt_d    = byte_cnt_q + 1'b1;
        wd_d          = '0;
        state_d       = S_WAIT;
      end
      S_RD: begin
        // Reading addr 0 on the final byte also raises cs.
        spi_reg_read = 1'b1;
        spi_reg_addr = last_byte ? 3'd0 : 3'd1;
        rx_data_d    = spi_rdata;
        rx_valid_d   = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = last_byte ? S_DONE : S_WR;
        end
      end
      S_END: begin
        spi_reg_read = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done[rx_id_q] = 1'b1;
        err           = err_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      rx_id_q      <= 1'b0;
      sel_q        <= 2'd0;
      // NOTE: the header bank and rx_data are reset too, so the bus and
      // rx_data read 0 after reset rather than stale transaction data.
      hdr_q        <= '0;
      hdr_len_q    <= 3'd0;
      rx_len_q     <= '0;
      byte_cnt_q   <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rx_id_q      <= rx_id_d;
      sel_q        <= sel_d;
      hdr_q        <= hdr_d;
      hdr_len_q    <= hdr_len_d;
      rx_len_q     <= rx_len_d;
      byte_cnt_q   <= byte_cnt_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_id       = rx_id_q;
  assign spi_reg_sel = sel_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_seq_arb.sv
// Directed bench for spi_seq_arb with a behavioural spi byte engine model.
module tb_spi_seq_arb;

  localparam int HDR_BYTES = 5;
  localparam int LEN_W     = 8;
  localparam int TO_W      = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [3:0]               req_sel;
  logic [2*8*HDR_BYTES-1:0] req_hdr;
  logic [5:0]               req_hdr_len;
  logic [2*LEN_W-1:0]       req_rx_len;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [7:0]               rx_data;
  logic                     rx_id;
  logic [1:0]               done;
  logic                     err;
  logic                     busy;
  logic [2:0]               spi_reg_addr;
  logic [7:0]               spi_reg_data;
  logic [1:0]               spi_reg_sel;
  logic                     spi_reg_read;
  logic                     spi_reg_write;
  logic [7:0]               spi_rdata;
  logic                     spi_int;

  spi_seq_arb #(.HDR_BYTES(HDR_BYTES), .LEN_W(LEN_W), .FILL(8'hFF), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_hdr(req_hdr), .req_hdr_len(req_hdr_len), .req_rx_len(req_rx_len),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_id(rx_id),
    .done(done), .err(err), .busy(busy),
    .spi_reg_addr(spi_reg_addr), .spi_reg_data(spi_reg_data), .spi_reg_sel(spi_reg_sel),
    .spi_reg_read(spi_reg_read), .spi_reg_write(spi_reg_write),
    .spi_rdata(spi_rdata), .spi_int(spi_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // spi model: a write clears int and completes the byte 3 cycles later;
  // the received byte is 0x50 + number of bytes clocked since reset.
  logic       stuck;
  int         cd;
  logic [7:0] nbytes;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_int   <= 1'b0;
      spi_rdata <= 8'h00;
      cd        <= 0;
      nbytes    <= 8'h00;
    end else if (spi_reg_write) begin
      spi_int <= 1'b0;
      cd      <= 3;
      nbytes  <= nbytes + 8'h01;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1 && !stuck) begin
        spi_int   <= 1'b1;
        spi_rdata <= 8'h50 + nbytes;
      end
    end
  end

  // Bus log entry: {write, addr, data}; read entries carry data 0.
  logic [11:0] ev_q[$];
  int          ev_t[$];
  logic [8:0]  rx_q[$];
  logic        gnt_q[$];
  int          done_cnt = 0;
  logic [1:0]  last_done = 2'b00;
  logic        last_err = 1'b0;
  int          viol = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (spi_reg_write) begin
        ev_q.push_back({1'b1, spi_reg_addr, spi_reg_data});
        ev_t.push_back(cyc);
      end else if (spi_reg_read) begin
        ev_q.push_back({1'b0, spi_reg_addr, 8'h00});
        ev_t.push_back(cyc);
      end
      if ((spi_reg_read && spi_reg_write) ||
          (!spi_reg_read && !spi_reg_write && (spi_reg_addr != 3'd0 || spi_reg_data != 8'd0)))
        viol++;
      if (rx_valid && rx_ready) rx_q.push_back({rx_id, rx_data});
      if (|req_ready) gnt_q.push_back(req_ready[1]);
      if (|done) begin
        done_cnt++;
        last_done = done;
        last_err  = err;
      end
    end
  end

  task automatic clear_logs();
    ev_q.delete(); ev_t.delete(); rx_q.delete(); gnt_q.delete();
    last_done = 2'b00;
    last_err  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00; rx_ready = 1'b1; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic post(input int p, input logic [1:0] sel, input logic [39:0] hdr,
                      input logic [2:0] hl, input logic [7:0] rl);
    req_sel[2*p +: 2]     = sel;
    req_hdr[40*p +: 40]   = hdr;
    req_hdr_len[3*p +: 3] = hl;
    req_rx_len[8*p +: 8]  = rl;
  endtask

  task automatic issue(input int p, input logic [1:0] sel, input logic [39:0] hdr,
                       input logic [2:0] hl, input logic [7:0] rl);
    bit ok = 1'b0;
    post(p, sel, hdr, hl, rl);
    req_valid[p] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; break; end
    end
    if (!ok) check("grant_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start = done_cnt;
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      if (done_cnt > start) begin ok = 1'b1; break; end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic wait_rx_valid(input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (rx_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("rx_valid_timeout", 0, 1);
  endtask

  task automatic check_events(input string tag, input logic [11:0] exp[$]);
    check({tag, "_nev"}, ev_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ev_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp[i]);
  endtask

  logic [11:0] exp_ev[$];
  logic [7:0]  d0;
  int          n_ev;
  int          dc;
  bit          stable;

  initial begin
    req_sel = '0; req_hdr = '0; req_hdr_len = '0; req_rx_len = '0;
    reset = 1'b1; req_valid = 2'b00; rx_ready = 1'b1; stuck = 1'b0;

    // Test 2: both valid from reset; outputs quiet during reset, grants alternate.
    post(0, 2'd0, 40'h11, 3'd1, 8'd0);
    post(1, 2'd1, 40'h22, 3'd1, 8'd0);
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done", done, 2'b00);
    check("rst_strobes", {spi_reg_read, spi_reg_write}, 2'b00);
    check("rst_bus", {spi_reg_addr, spi_reg_data, spi_reg_sel}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    for (int k = 0; k < 300 && gnt_q.size() < 4; k++) @(posedge clk);
    #1 req_valid = 2'b00;
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    check("rr_ngrant", gnt_q.size(), 4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++)
      check($sformatf("rr_grant%0d", i), gnt_q[i], i % 2);

    // Test 1: one header byte, three received bytes.
    do_reset();
    issue(0, 2'd2, 40'h9F, 3'd1, 8'd3);
    wait_done(200);
    exp_ev = '{12'h89F, 12'h9FF, 12'h100, 12'h9FF, 12'h100, 12'h9FF, 12'h000};
    check_events("t1", exp_ev);
    check("t1_nrx", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check($sformatf("t1_rx%0d", i), rx_q[i], {1'b0, 8'h52 + 8'(i)});
    check("t1_done", last_done, 2'b01);
    check("t1_err", last_err, 0);

    // Test 3: four header bytes, nothing received, port 1.
    do_reset();
    issue(1, 2'd3, 40'h00_5634_1203, 3'd4, 8'd0);
    wait_done(200);
    exp_ev = '{12'h803, 12'h912, 12'h934, 12'h956, 12'h000};
    check_events("t3", exp_ev);
    check("t3_nrx", rx_q.size(), 0);
    check("t3_done", last_done, 2'b10);
    check("t3_err", last_err, 0);

    // Test 4: consumer stalls on the second received byte.
    do_reset();
    issue(0, 2'd0, 40'h0B, 3'd1, 8'd3);
    for (int k = 0; k < 200 && rx_q.size() < 1; k++) @(posedge clk);
    #1 rx_ready = 1'b0;
    wait_rx_valid(100);
    n_ev = ev_q.size();
    d0 = rx_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rx_valid || rx_data !== d0) stable = 1'b0;
    end
    check("t4_stable", stable, 1);
    check("t4_held_data", d0, 8'h53);
    check("t4_no_bus", ev_q.size(), n_ev);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    wait_done(200);
    if (ev_q.size() > n_ev) check("t4_next_ev", ev_q[n_ev], 12'h9FF);
    else                    check("t4_next_ev_missing", ev_q.size(), n_ev + 1);
    check("t4_nrx", rx_q.size(), 3);
    if (rx_q.size() == 3) check("t4_rx2", rx_q[2], 9'h054);

    // Test 5a: illegal header lengths finish with err and no bus traffic.
    do_reset();
    issue(0, 2'd0, 40'h77, 3'd0, 8'd2);
    wait_done(50);
    check("t5a_nev", ev_q.size(), 0);
    check("t5a_done", last_done, 2'b01);
    check("t5a_err", last_err, 1);
    issue(1, 2'd0, 40'h77, 3'd6, 8'd2);
    wait_done(50);
    check("t5a6_nev", ev_q.size(), 0);
    check("t5a6_done", last_done, 2'b10);
    check("t5a6_err", last_err, 1);

    // Test 5b: interrupt never arrives; watchdog closes the transaction.
    do_reset();
    stuck = 1'b1;
    issue(0, 2'd0, 40'h3412, 3'd2, 8'd1);
    wait_done(200);
    exp_ev = '{12'h812, 12'h000};
    check_events("t5b", exp_ev);
    if (ev_t.size() == 2) check("t5b_wd_cycles", ev_t[1] - ev_t[0], 1 << TO_W);
    check("t5b_done", last_done, 2'b01);
    check("t5b_err", last_err, 1);

    // Test 6: asynchronous reset while holding a received byte.
    do_reset();
    rx_ready = 1'b0;
    issue(0, 2'd1, 40'hAA, 3'd1, 8'd2);
    wait_rx_valid(100);
    dc = done_cnt;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rx_valid", rx_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_strobes", {spi_reg_read, spi_reg_write, done}, 0);
    check("t6_rx_data", rx_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    rx_ready = 1'b1;
    check("t6_no_done", done_cnt, dc);
    issue(0, 2'd0, 40'h05, 3'd1, 8'd1);
    wait_done(200);
    exp_ev = '{12'h805, 12'h9FF, 12'h000};
    check_events("t6", exp_ev);
    check("t6_nrx", rx_q.size(), 1);
    if (rx_q.size() == 1) check("t6_rx0", rx_q[0], 9'h052);
    check("t6_done", last_done, 2'b01);
    check("t6_err", last_err, 0);

    check("bus_exclusive", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
